// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register of the RV32 core: captures ALU result and control, resolves branches.
// Optional macro EX_MEM_MISALIGN_EN enables the taken-target word-alignment check.
module ex_mem_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_flush,
    input  logic               mem_stall,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_z,
    input  logic               alu_c,
    input  logic               alu_v,
    input  logic               is_branch,
    input  logic               is_jump,
    input  logic [2:0]         funct3,
    input  logic [XLEN-1:0]    br_target,
    input  logic [XLEN-1:0]    pc_plus4,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    output logic               m_valid,
    output logic [XLEN-1:0]    m_alu_out,
    output logic [XLEN-1:0]    m_store_data,
    output logic [XLEN-1:0]    m_link,
    output logic [RADDR_W-1:0] m_rd,
    output logic               m_reg_write,
    output logic               m_mem_read,
    output logic               m_mem_write,
    output logic               m_mem_to_reg,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               m_taken,
    output logic               misalign_exc
);

    logic cap;
    logic valid_in;
    logic cond;
    logic taken_in;
    logic mis;
    logic red_done;

    assign cap      = ~mem_stall;
    assign redirect = m_taken & m_valid & ~red_done;
    assign valid_in = ex_valid & ~ex_flush & ~redirect;
    assign taken_in = is_jump | (is_branch & cond);

    // Flags assume the ALU performed a - b; cFlag=1 means a >= b unsigned.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = alu_z;
            3'b001:  cond = ~alu_z;
            3'b100:  cond = alu_out[XLEN-1] ^ alu_v;
            3'b101:  cond = ~(alu_out[XLEN-1] ^ alu_v);
            3'b110:  cond = ~alu_c;
            3'b111:  cond = alu_c;
            default: cond = 1'b0;
        endcase
    end

`ifdef EX_MEM_MISALIGN_EN
    assign mis = taken_in & valid_in & (br_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_exc <= 1'b0;
        end else if (cap) begin
            misalign_exc <= mis;
        end
    end
`else
    assign mis          = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b0;
            m_alu_out    <= '0;
            m_store_data <= '0;
            m_link       <= '0;
            m_rd         <= '0;
            m_reg_write  <= 1'b0;
            m_mem_read   <= 1'b0;
            m_mem_write  <= 1'b0;
            m_mem_to_reg <= 1'b0;
            m_taken      <= 1'b0;
            redirect_pc  <= '0;
            red_done     <= 1'b0;
        end else if (cap) begin
            m_valid      <= valid_in;
            m_alu_out    <= alu_out;
            m_store_data <= rs2_data;
            m_link       <= pc_plus4;
            m_rd         <= rd;
            m_reg_write  <= reg_write & valid_in & ~mis;
            m_mem_read   <= mem_read & valid_in & ~mis;
            m_mem_write  <= mem_write & valid_in & ~mis;
            m_mem_to_reg <= mem_to_reg & valid_in;
            m_taken      <= taken_in & valid_in & ~mis;
            redirect_pc  <= br_target;
            red_done     <= 1'b0;
        end else begin
            // Held taken branch: remember the pulse so it is issued only once.
            red_done     <= red_done | redirect;
        end
    end

endmodule
